ntt_ctrl: RTL and testbench

NTT_CTRL -- requirements
Module: ntt_ctrl

---
 rtl/ntt_pkg.sv | 66 ++++++
 rtl/ntt_ctrl_if.sv | 52 +++++
 rtl/ntt_addr_gen.sv | 38 +++
 rtl/ntt_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_ntt_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// ============================================================================
// ntt_pkg -- shared constants, FSM state type and modular helpers for the
//            256-point forward NTT controller (Dilithium modulus).
//
// Contents
//   Q        : prime modulus 8380417
//   N        : transform length (256 coefficients)
//   NTT_DW   : default coefficient width (23 bits)
//   NTT_AW   : default coefficient address width (8 bits)
//   STAGES   : number of butterfly stages (log2 N)
//   BFLY     : butterflies per stage (N/2)
//   ntt_state_t : controller FSM states IDLE/RUN/DRAIN/DONE
//   mod_add / mod_sub / mod_mul : reference arithmetic mod Q, used by
//                                 butterfly models around the controller
// ============================================================================
package ntt_pkg;

   localparam int unsigned Q      = 32'd8380417;
   localparam int unsigned N      = 32'd256;
   localparam int unsigned NTT_DW = 32'd23;
   localparam int unsigned NTT_AW = 32'd8;
   localparam int unsigned STAGES = 32'd8;
   localparam int unsigned BFLY   = N / 32'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } ntt_state_t;

   // (a + b) mod Q, operands already reduced
   function automatic logic [NTT_DW-1:0] mod_add(input logic [NTT_DW-1:0] a,
                                                 input logic [NTT_DW-1:0] b);
      logic [NTT_DW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (NTT_DW+1)'(Q)) begin
         s = s - (NTT_DW+1)'(Q);
      end else begin
         s = s;
      end
      return s[NTT_DW-1:0];
   endfunction

   // (a - b) mod Q, operands already reduced
   function automatic logic [NTT_DW-1:0] mod_sub(input logic [NTT_DW-1:0] a,
                                                 input logic [NTT_DW-1:0] b);
      logic [NTT_DW:0] d;
      if (a >= b) begin
         d = {1'b0, a} - {1'b0, b};
      end else begin
         d = {1'b0, a} + (NTT_DW+1)'(Q) - {1'b0, b};
      end
      return d[NTT_DW-1:0];
   endfunction

   // (a * b) mod Q
   function automatic logic [NTT_DW-1:0] mod_mul(input logic [NTT_DW-1:0] a,
                                                 input logic [NTT_DW-1:0] b);
      logic [2*NTT_DW-1:0] p;
      p = (2*NTT_DW)'(a) * (2*NTT_DW)'(b);
      p = p % (2*NTT_DW)'(Q);
      return p[NTT_DW-1:0];
   endfunction

endpackage

// File: rtl/ntt_ctrl_if.sv
// ============================================================================
// ntt_ctrl_if -- bundle of every non-clock signal between the NTT controller
//                and its environment (coefficient RAM, twiddle ROM,
//                external combinational butterfly, run control/status).
//
// Signals
//   start                 : one-cycle run request
//   rd_en/rd_addr0/1      : RAM read request; rd_data0/1 valid next cycle
//   tw_addr/tw_data       : twiddle ROM, one-cycle latency
//   bu_x/bu_y/bu_tf       : butterfly operands;  bu_a/bu_b : its results
//   wr_en/wr_addr0/1/wr_data0/1 : RAM write-back
//   busy/done             : run status and completion pulse
// Modports
//   master : controller side,  slave : environment side
// ============================================================================
interface ntt_ctrl_if #(
   parameter int DW = 23,
   parameter int AW = 8
);
   logic          start;
   logic          rd_en;
   logic [AW-1:0] rd_addr0;
   logic [AW-1:0] rd_addr1;
   logic [DW-1:0] rd_data0;
   logic [DW-1:0] rd_data1;
   logic [7:0]    tw_addr;
   logic [DW-1:0] tw_data;
   logic [DW-1:0] bu_x;
   logic [DW-1:0] bu_y;
   logic [DW-1:0] bu_tf;
   logic [DW-1:0] bu_a;
   logic [DW-1:0] bu_b;
   logic          wr_en;
   logic [AW-1:0] wr_addr0;
   logic [AW-1:0] wr_addr1;
   logic [DW-1:0] wr_data0;
   logic [DW-1:0] wr_data1;
   logic          busy;
   logic          done;

   modport master (
      input  start, rd_data0, rd_data1, tw_data, bu_a, bu_b,
      output rd_en, rd_addr0, rd_addr1, tw_addr, bu_x, bu_y, bu_tf,
             wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1, busy, done
   );

   modport slave (
      output start, rd_data0, rd_data1, tw_data, bu_a, bu_b,
      input  rd_en, rd_addr0, rd_addr1, tw_addr, bu_x, bu_y, bu_tf,
             wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1, busy, done
   );
endinterface

// File: rtl/ntt_addr_gen.sv
// ============================================================================
// ntt_addr_gen -- combinational Cooley-Tukey index generator.
//
// For stage s (0..7) and butterfly b (0..127), with len = 128 >> s:
//   j      = ((b >> (7-s)) << (8-s)) | (b & (len-1))   top operand index
//   j+len                                               bottom operand index
//   tw     = (1 << s) + (b >> (7-s))                    twiddle ROM index
//
// Ports
//   s_i  : stage number         b_i  : butterfly number within stage
//   j_o  : first index          jl_o : second index (j + len)
//   tw_o : twiddle address
// ============================================================================
module ntt_addr_gen (
   input  logic [2:0] s_i,
   input  logic [6:0] b_i,
   output logic [7:0] j_o,
   output logic [7:0] jl_o,
   output logic [7:0] tw_o
);

   logic [7:0] len_s;
   logic [7:0] grp_s;
   logic [7:0] b_ext_s;
   logic [3:0] grp_shift_s;

   // b >> (7-s) is the butterfly group; each group spans 2*len coefficients
   always_comb begin
      b_ext_s     = {1'b0, b_i};
      len_s       = 8'd128 >> s_i;
      grp_s       = b_ext_s >> (3'd7 - s_i);
      grp_shift_s = 4'd8 - {1'b0, s_i};
      j_o         = (grp_s << grp_shift_s) | (b_ext_s & (len_s - 8'd1));
      jl_o        = j_o + len_s;
      tw_o        = (8'd1 << s_i) + grp_s;
   end

endmodule

// File: rtl/ntt_ctrl.sv
// ============================================================================
// ntt_ctrl -- sequencer for an in-place 256-point forward NTT.
//
// Each run walks 8 stages of 128 butterflies.  One butterfly is issued per
// cycle: the RAM read and twiddle fetch go out registered, the operands come
// back one cycle later and pass straight to the external combinational
// butterfly, and its results are registered into the write port, so a write
// lands two cycles after its issue.  Two DRAIN cycles between stages let the
// last writes of a stage retire before the next stage reads.
//
// With start sampled at the edge closing cycle 0: stage s issues in cycles
// 1+130s .. 128+130s, the last write is in cycle 1040, busy is high in
// cycles 1..1040 and done pulses in cycle 1041.  start is ignored unless idle.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears every register
//   bus    : ntt_ctrl_if.master (RAM, twiddle ROM, butterfly, status)
//   cyc_cnt: (NTT_CTRL_PERF_EN only) busy-cycle count of the latest run
//
// Build option
//   NTT_CTRL_PERF_EN : adds the 11-bit cyc_cnt output and its counter
// ============================================================================
module ntt_ctrl
   import ntt_pkg::*;
#(
   parameter int DW = NTT_DW,
   parameter int AW = NTT_AW
) (
   input  logic          clk,
   input  logic          rst_n,
   ntt_ctrl_if.master    bus
`ifdef NTT_CTRL_PERF_EN
   ,
   output logic [10:0]   cyc_cnt
`endif
);

   localparam logic [6:0] LAST_B = 7'(BFLY - 32'd1);
   localparam logic [2:0] LAST_S = 3'(STAGES - 32'd1);

   ntt_state_t    state_q;
   logic [2:0]    s_q;
   logic [6:0]    b_q;
   logic          drn_q;
   logic          rd_en_q;
   logic [AW-1:0] rd_addr0_q;
   logic [AW-1:0] rd_addr1_q;
   logic [7:0]    tw_addr_q;
   logic          busy_q;
   logic          done_q;

   logic          v1_q;
   logic [AW-1:0] pa0_q;
   logic [AW-1:0] pa1_q;
   logic          wr_en_q;
   logic [AW-1:0] wr_addr0_q;
   logic [AW-1:0] wr_addr1_q;
   logic [DW-1:0] wr_data0_q;
   logic [DW-1:0] wr_data1_q;

   logic [2:0]    nxt_s_d;
   logic [6:0]    nxt_b_d;
   logic [7:0]    gen_j_s;
   logic [7:0]    gen_jl_s;
   logic [7:0]    gen_tw_s;

   // Index of the butterfly that the coming edge will issue, so the
   // address registers are loaded already decoded
   always_comb begin
      nxt_s_d = 3'd0;
      nxt_b_d = 7'd0;
      case (state_q)
         IDLE: begin
            nxt_s_d = 3'd0;
            nxt_b_d = 7'd0;
         end
         RUN: begin
            nxt_s_d = s_q;
            nxt_b_d = b_q + 7'd1;
         end
         DRAIN: begin
            nxt_s_d = s_q + 3'd1;
            nxt_b_d = 7'd0;
         end
         default: begin
            nxt_s_d = 3'd0;
            nxt_b_d = 7'd0;
         end
      endcase
   end

   ntt_addr_gen u_addr_gen (
      .s_i  (nxt_s_d),
      .b_i  (nxt_b_d),
      .j_o  (gen_j_s),
      .jl_o (gen_jl_s),
      .tw_o (gen_tw_s)
   );

   // Run sequencer: stage/butterfly counters and registered read/status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         s_q        <= 3'd0;
         b_q        <= 7'd0;
         drn_q      <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr0_q <= {AW{1'b0}};
         rd_addr1_q <= {AW{1'b0}};
         tw_addr_q  <= 8'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state_q    <= RUN;
                  s_q        <= 3'd0;
                  b_q        <= 7'd0;
                  busy_q     <= 1'b1;
                  rd_en_q    <= 1'b1;
                  rd_addr0_q <= AW'(gen_j_s);
                  rd_addr1_q <= AW'(gen_jl_s);
                  tw_addr_q  <= gen_tw_s;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               if (b_q == LAST_B) begin
                  state_q <= DRAIN;
                  drn_q   <= 1'b0;
                  rd_en_q <= 1'b0;
               end else begin
                  b_q        <= nxt_b_d;
                  rd_addr0_q <= AW'(gen_j_s);
                  rd_addr1_q <= AW'(gen_jl_s);
                  tw_addr_q  <= gen_tw_s;
               end
            end
            DRAIN: begin
               // second DRAIN cycle carries the stage's last write
               if (!drn_q) begin
                  drn_q <= 1'b1;
               end else if (s_q == LAST_S) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q    <= RUN;
                  s_q        <= nxt_s_d;
                  b_q        <= 7'd0;
                  rd_en_q    <= 1'b1;
                  rd_addr0_q <= AW'(gen_j_s);
                  rd_addr1_q <= AW'(gen_jl_s);
                  tw_addr_q  <= gen_tw_s;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               rd_en_q <= 1'b0;
            end
         endcase
      end
   end

   // Two-slot write-back pipeline: addresses follow the read, data captured
   // from the butterfly the cycle the operands are present
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q       <= 1'b0;
         pa0_q      <= {AW{1'b0}};
         pa1_q      <= {AW{1'b0}};
         wr_en_q    <= 1'b0;
         wr_addr0_q <= {AW{1'b0}};
         wr_addr1_q <= {AW{1'b0}};
         wr_data0_q <= {DW{1'b0}};
         wr_data1_q <= {DW{1'b0}};
      end else begin
         v1_q    <= rd_en_q;
         pa0_q   <= rd_addr0_q;
         pa1_q   <= rd_addr1_q;
         wr_en_q <= v1_q;
         if (v1_q) begin
            wr_addr0_q <= pa0_q;
            wr_addr1_q <= pa1_q;
            wr_data0_q <= bus.bu_a;
            wr_data1_q <= bus.bu_b;
         end else begin
            wr_addr0_q <= wr_addr0_q;
            wr_addr1_q <= wr_addr1_q;
            wr_data0_q <= wr_data0_q;
            wr_data1_q <= wr_data1_q;
         end
      end
   end

`ifdef NTT_CTRL_PERF_EN
   logic [10:0] cyc_q;

   // Busy-cycle counter: restarts on an accepted start, holds once idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q <= 11'd0;
      end else if ((state_q == IDLE) && bus.start) begin
         cyc_q <= 11'd0;
      end else if (busy_q) begin
         cyc_q <= cyc_q + 11'd1;
      end else begin
         cyc_q <= cyc_q;
      end
   end

   assign cyc_cnt = cyc_q;
`endif

   assign bus.rd_en    = rd_en_q;
   assign bus.rd_addr0 = rd_addr0_q;
   assign bus.rd_addr1 = rd_addr1_q;
   assign bus.tw_addr  = tw_addr_q;
   assign bus.bu_x     = bus.rd_data0;
   assign bus.bu_y     = bus.rd_data1;
   assign bus.bu_tf    = bus.tw_data;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr0 = wr_addr0_q;
   assign bus.wr_addr1 = wr_addr1_q;
   assign bus.wr_data0 = wr_data0_q;
   assign bus.wr_data1 = wr_data1_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_ntt_ctrl.sv
// ============================================================================
// tb_ntt_ctrl -- directed bench for ntt_ctrl: coefficient RAM, twiddle ROM
// and a Cooley-Tukey butterfly around the controller, a golden NTT model,
// and a linear sequence of directed runs (zero RAM, delta, random data,
// late start pulses, mid-run reset).  Optional NTT_CTRL_PERF_EN checks.
// ============================================================================
module tb_ntt_ctrl;
   import ntt_pkg::*;

   localparam int DW = 23;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   ntt_ctrl_if #(.DW(DW), .AW(AW)) bus ();

`ifdef NTT_CTRL_PERF_EN
   logic [10:0] cyc_cnt;
`endif

   ntt_ctrl #(.DW(DW), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef NTT_CTRL_PERF_EN
      ,
      .cyc_cnt (cyc_cnt)
`endif
   );

   // ---------------- environment models ----------------
   logic [DW-1:0] mem [256];
   logic [DW-1:0] gold [256];
   logic          ld_en;
   logic [7:0]    ld_addr;
   logic [DW-1:0] ld_val;
   logic [DW-1:0] t_s;

   function automatic logic [DW-1:0] tw_val(input logic [7:0] k);
      return DW'((32'(k) * 32'd1753 + 32'd17) % Q);
   endfunction

   assign t_s        = mod_mul(bus.bu_tf, bus.bu_y);
   assign bus.bu_a   = mod_add(bus.bu_x, t_s);
   assign bus.bu_b   = mod_sub(bus.bu_x, t_s);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rd_data0 <= '0;
         bus.rd_data1 <= '0;
         bus.tw_data  <= '0;
      end else begin
         if (ld_en) mem[ld_addr] <= ld_val;
         if (bus.wr_en) begin
            mem[bus.wr_addr0] <= bus.wr_data0;
            mem[bus.wr_addr1] <= bus.wr_data1;
         end
         if (bus.rd_en) begin
            bus.rd_data0 <= mem[bus.rd_addr0];
            bus.rd_data1 <= mem[bus.rd_addr1];
         end
         bus.tw_data <= tw_val(bus.tw_addr);
      end
   end

   // ---------------- bookkeeping ----------------
   int n_assert = 0;
   int n_fail   = 0;

   int wr_cnt, nz_cnt, done_cnt, done_cyc, busy_cnt, busy_first, busy_last;
   logic [63:0] a0_c1, a1_c1, tw_c1, a0_c1038, a1_c1038, tw_c1038;
   logic [63:0] rden_c129, a0_c131, a1_c131, tw_c131;
   logic [63:0] wa0_c3, wa1_c3, we_c3, wa0_c1040;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // mode 0: all zero, 1: delta at index 0, 2: random residues
   task automatic load(input int mode);
      logic [DW-1:0] v;
      for (int i = 0; i < 256; i++) begin
         if (mode == 0)      v = '0;
         else if (mode == 1) v = (i == 0) ? DW'(1) : DW'(0);
         else                v = DW'($urandom_range(Q - 1, 0));
         ld_en   = 1'b1;
         ld_addr = 8'(i);
         ld_val  = v;
         gold[i] = v;
         step();
      end
      ld_en = 1'b0;
   endtask

   task automatic ref_ntt();
      int k;
      logic [DW-1:0] z, t;
      k = 0;
      for (int len = 128; len > 0; len = len >> 1) begin
         for (int st = 0; st < 256; st = st + 2 * len) begin
            k++;
            z = tw_val(8'(k));
            for (int j = st; j < st + len; j++) begin
               t           = mod_mul(z, gold[j + len]);
               gold[j+len] = mod_sub(gold[j], t);
               gold[j]     = mod_add(gold[j], t);
            end
         end
      end
   endtask

   // start in cycle 0, observe cycles 1..1045 (bounded)
   task automatic run_ntt(input bit poke500, input bit poke_done);
      wr_cnt = 0; nz_cnt = 0; done_cnt = 0; done_cyc = -1;
      busy_cnt = 0; busy_first = -1; busy_last = -1;
      bus.start = 1'b1;
      for (int c = 1; c <= 1045; c++) begin
         step();
         bus.start = (poke500 && c == 500) || (poke_done && c == 1041);
         if (bus.wr_en === 1'b1) begin
            wr_cnt++;
            if (bus.wr_data0 !== '0 || bus.wr_data1 !== '0) nz_cnt++;
         end
         if (bus.done === 1'b1) begin done_cnt++; done_cyc = c; end
         if (bus.busy === 1'b1) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = c;
            busy_last = c;
         end
         if (c == 1)    begin a0_c1 = 64'(bus.rd_addr0); a1_c1 = 64'(bus.rd_addr1); tw_c1 = 64'(bus.tw_addr); end
         if (c == 3)    begin we_c3 = 64'(bus.wr_en); wa0_c3 = 64'(bus.wr_addr0); wa1_c3 = 64'(bus.wr_addr1); end
         if (c == 129)  rden_c129 = 64'(bus.rd_en);
         if (c == 131)  begin a0_c131 = 64'(bus.rd_addr0); a1_c131 = 64'(bus.rd_addr1); tw_c131 = 64'(bus.tw_addr); end
         if (c == 1038) begin a0_c1038 = 64'(bus.rd_addr0); a1_c1038 = 64'(bus.rd_addr1); tw_c1038 = 64'(bus.tw_addr); end
         if (c == 1040) wa0_c1040 = 64'(bus.wr_addr0);
      end
      bus.start = 1'b0;
   endtask

   task automatic check_timing(input string p);
      chk({p, "_rd0_c1"}, a0_c1, 64'd0);
      chk({p, "_rd1_c1"}, a1_c1, 64'd128);
      chk({p, "_tw_c1"}, tw_c1, 64'd1);
      chk({p, "_rd0_c1038"}, a0_c1038, 64'd254);
      chk({p, "_rd1_c1038"}, a1_c1038, 64'd255);
      chk({p, "_tw_c1038"}, tw_c1038, 64'd255);
      chk({p, "_done_cnt"}, 64'(done_cnt), 64'd1);
      chk({p, "_done_cyc"}, 64'(done_cyc), 64'd1041);
      chk({p, "_busy_first"}, 64'(busy_first), 64'd1);
      chk({p, "_busy_last"}, 64'(busy_last), 64'd1040);
      chk({p, "_busy_cnt"}, 64'(busy_cnt), 64'd1040);
      chk({p, "_wr_cnt"}, 64'(wr_cnt), 64'd1024);
   endtask

   task automatic check_gold(input string p);
      int mis;
      mis = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) mis++;
      chk({p, "_gold_mismatches"}, 64'(mis), 64'd0);
   endtask

   task automatic check_all_ones(input string p);
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== DW'(1)) bad++;
      chk({p, "_not_one"}, 64'(bad), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int leak;
      bus.start = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_val = '0;
      rst_n = 1'b0;
      repeat (3) step();

      // reset values
      chk("rst_rd_en", 64'(bus.rd_en), 64'd0);
      chk("rst_rd_addr0", 64'(bus.rd_addr0), 64'd0);
      chk("rst_rd_addr1", 64'(bus.rd_addr1), 64'd0);
      chk("rst_tw_addr", 64'(bus.tw_addr), 64'd0);
      chk("rst_bu_x", 64'(bus.bu_x), 64'd0);
      chk("rst_bu_tf", 64'(bus.bu_tf), 64'd0);
      chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
      chk("rst_wr_addr1", 64'(bus.wr_addr1), 64'd0);
      chk("rst_wr_data0", 64'(bus.wr_data0), 64'd0);
      chk("rst_wr_data1", 64'(bus.wr_data1), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_state", 64'(dut.state_q), 64'(IDLE));
`ifdef NTT_CTRL_PERF_EN
      chk("rst_cyc_cnt", 64'(cyc_cnt), 64'd0);
`endif
      rst_n = 1'b1;
      step();

      // all-zero RAM, start pokes in cycle 500 and in the DONE cycle
      load(0);
      run_ntt(1'b1, 1'b1);
      check_timing("zero");
      chk("zero_nonzero_writes", 64'(nz_cnt), 64'd0);
      chk("zero_wr_en_c3", we_c3, 64'd1);
      chk("zero_wr_addr0_c3", wa0_c3, 64'd0);
      chk("zero_wr_addr1_c3", wa1_c3, 64'd128);
      chk("zero_wr_addr0_c1040", wa0_c1040, 64'd254);
      chk("zero_rd_en_drain", rden_c129, 64'd0);
      chk("zero_rd0_c131", a0_c131, 64'd0);
      chk("zero_rd1_c131", a1_c131, 64'd64);
      chk("zero_tw_c131", tw_c131, 64'd2);
      chk("zero_idle_after", 64'(bus.busy), 64'd0);
`ifdef NTT_CTRL_PERF_EN
      chk("perf_run1", 64'(cyc_cnt), 64'd1040);
`endif

      // delta input transforms to all ones
      load(1);
      ref_ntt();
      run_ntt(1'b0, 1'b0);
      check_timing("delta");
      check_all_ones("delta");
      check_gold("delta");
`ifdef NTT_CTRL_PERF_EN
      chk("perf_run2", 64'(cyc_cnt), 64'd1040);
`endif

      // random residues against the golden model
      load(2);
      ref_ntt();
      run_ntt(1'b0, 1'b0);
      check_gold("rand");

      // reset in cycle 400 of a run
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (399) step();
      rst_n = 1'b0;
      step();
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_rd_en", 64'(bus.rd_en), 64'd0);
      chk("midrst_wr_en", 64'(bus.wr_en), 64'd0);
      chk("midrst_state", 64'(dut.state_q), 64'(IDLE));
`ifdef NTT_CTRL_PERF_EN
      chk("midrst_cyc_cnt", 64'(cyc_cnt), 64'd0);
`endif
      step();
      rst_n = 1'b1;
      leak = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) leak++;
      end
      chk("midrst_no_activity", 64'(leak), 64'd0);

      // fresh run after reset restarts from stage 0
      load(1);
      ref_ntt();
      run_ntt(1'b0, 1'b0);
      check_timing("again");
      check_all_ones("again");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
